// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature encoder capture block: status word
// layout, step encoding and the decode/saturation helpers.
package encoder_pkg;

  localparam int unsigned FIELD_W = 16;
  localparam int unsigned POS_LSB = 0;
  localparam int unsigned VEL_LSB = 16;

  localparam logic signed [FIELD_W-1:0] VEL_MAX = 16'sh7FFF;
  localparam logic signed [FIELD_W-1:0] VEL_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_INC     = 2'd1,
    STEP_DEC     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  typedef enum logic {
    DEC_SETTLE = 1'b0,
    DEC_TRACK  = 1'b1
  } dec_state_t;

  // prev/cur are {A,B}; forward order is 00 -> 01 -> 11 -> 10 -> 00
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_INC;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_DEC;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ILLEGAL;
      default:                            s = STEP_NONE;
    endcase
    return s;
  endfunction

  function automatic logic signed [FIELD_W-1:0] sat_step(
    input logic signed [FIELD_W-1:0] acc,
    input step_t                     step
  );
    logic signed [FIELD_W-1:0] r;
    r = acc;
    case (step)
      STEP_INC: if (acc != VEL_MAX) r = acc + 16'sd1;
      STEP_DEC: if (acc != VEL_MIN) r = acc - 16'sd1;
      default:  r = acc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/encoder_input_filter.sv
// Synchroniser chain plus run-length glitch filter for one encoder channel.
// The output level flips only after FILTER_LEN consecutive differing samples.
module encoder_input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       run_cnt;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= 1'b0;
      run_cnt <= '0;
    end else if (sync_out != level) begin
      if (run_cnt == LAST_CNT) begin
        level   <= sync_out;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: rtl/encoder_capture.sv
// Quadrature encoder front end: filtered 4x decode into a wrapping position and a
// saturating per-period velocity, published together as one coherent status word.
module encoder_capture
  import encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned PERIOD_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        clear,
  output logic [31:0] status_word,
  output logic        sample_strobe,
  output logic        error_flag
);

  // The filters come out of reset at 0; the decoder only starts comparing once
  // the levels present at reset have had time to propagate through them.
  localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + FILTER_LEN + 1;
  localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  localparam int unsigned PERIOD_W = $clog2(PERIOD_CYCLES);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYCLES - 1);

  logic                      filt_a;
  logic                      filt_b;
  logic [1:0]                filt_ab;
  logic [1:0]                prev_ab;
  dec_state_t                dec_state;
  dec_state_t                dec_state_next;
  logic [SETTLE_W-1:0]       settle_cnt;
  step_t                     step;
  logic [PERIOD_W-1:0]       period_cnt;
  logic                      terminal;
  logic signed [FIELD_W-1:0] vel_acc;
  logic signed [FIELD_W-1:0] vel_acc_next;
  logic [FIELD_W-1:0]        pos_q;
  logic [FIELD_W-1:0]        pos_next;

  encoder_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (enc_a),
    .level   (filt_a)
  );

  encoder_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (enc_b),
    .level   (filt_b)
  );

  assign filt_ab = {filt_a, filt_b};

  // Decoder state: settle after reset, then track transitions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_state <= DEC_SETTLE;
    end else begin
      dec_state <= dec_state_next;
    end
  end

  always_comb begin
    dec_state_next = dec_state;
    step           = STEP_NONE;
    case (dec_state)
      DEC_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) dec_state_next = DEC_TRACK;
      end
      DEC_TRACK: begin
        step = decode_step(prev_ab, filt_ab);
      end
      default: begin
        dec_state_next = DEC_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (dec_state == DEC_SETTLE) begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  // Tracking the filtered level every cycle also covers clear: the current
  // state is absorbed without producing a count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab <= '0;
    end else begin
      prev_ab <= filt_ab;
    end
  end

  assign pos_q        = status_word[POS_LSB +: FIELD_W];
  assign terminal     = (period_cnt == PERIOD_LAST);
  assign vel_acc_next = sat_step(vel_acc, step);

  always_comb begin
    pos_next = pos_q;
    case (step)
      STEP_INC: pos_next = pos_q + 16'd1;
      STEP_DEC: pos_next = pos_q - 16'd1;
      default:  pos_next = pos_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_word   <= '0;
      sample_strobe <= 1'b0;
      error_flag    <= 1'b0;
      vel_acc       <= '0;
      period_cnt    <= '0;
    end else if (clear) begin
      status_word   <= '0;
      sample_strobe <= 1'b0;
      error_flag    <= 1'b0;
      vel_acc       <= '0;
      period_cnt    <= '0;
    end else begin
      status_word[POS_LSB +: FIELD_W] <= pos_next;
      sample_strobe                   <= terminal;
      if (step == STEP_ILLEGAL) error_flag <= 1'b1;
      if (terminal) begin
        status_word[VEL_LSB +: FIELD_W] <= vel_acc_next;
        vel_acc                         <= '0;
        period_cnt                      <= '0;
      end else begin
        vel_acc    <= vel_acc_next;
        period_cnt <= period_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_encoder_capture.sv
// Directed + randomized bench for encoder_capture with a Gray-index reference model.
module tb_encoder_capture;

  localparam int unsigned S1   = 2;
  localparam int unsigned F1   = 4;
  localparam int unsigned P1   = 1000;
  localparam int unsigned LAT1 = S1 + F1 + 1;
  localparam int unsigned S2   = 2;
  localparam int unsigned F2   = 1;
  localparam int unsigned P2   = 33000;
  localparam int unsigned NSAT = 32800;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a1, b1, clear1, a2, b2, clear2;
  logic [31:0] sw1, sw2;
  logic        st1, st2, er1, er2;

  always #5 clk = ~clk;

  encoder_capture #(
    .SYNC_STAGES   (S1),
    .FILTER_LEN    (F1),
    .PERIOD_CYCLES (P1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enc_a         (a1),
    .enc_b         (b1),
    .clear         (clear1),
    .status_word   (sw1),
    .sample_strobe (st1),
    .error_flag    (er1)
  );

  encoder_capture #(
    .SYNC_STAGES   (S2),
    .FILTER_LEN    (F2),
    .PERIOD_CYCLES (P2)
  ) dut_sat (
    .clk           (clk),
    .reset_n       (reset_n),
    .enc_a         (a2),
    .enc_b         (b2),
    .clear         (clear2),
    .status_word   (sw2),
    .sample_strobe (st2),
    .error_flag    (er2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  logic [1:0]  ab1;
  logic [15:0] pos_m;
  logic        err_m;
  int          acc_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) tick();
  endtask

  // Position of a pin pair within the forward cycle 00,01,11,10
  function automatic int idx_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int idx);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    return seq[idx % 4];
  endfunction

  // +1 forward, -1 reverse, 0 none, 2 illegal
  function automatic int step_of(input logic [1:0] o, input logic [1:0] n);
    int d;
    d = (idx_of(n) - idx_of(o) + 4) % 4;
    if (d == 1) return 1;
    if (d == 3) return -1;
    return d;
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    return ab_of(idx_of(ab) + 1);
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    return ab_of(idx_of(ab) + 3);
  endfunction

  task automatic step1(input logic [1:0] nab, input int unsigned extra);
    int          d;
    logic [15:0] old_pos;
    d       = step_of(ab1, nab);
    old_pos = pos_m;
    ab1     = nab;
    {a1, b1} = nab;
    repeat (LAT1 - 1) tick();
    check("pos_before_latency", {16'h0, sw1[15:0]}, {16'h0, old_pos});
    tick();
    if (d == 2) begin
      err_m = 1'b1;
    end else begin
      pos_m = pos_m + 16'(d);
      acc_m = acc_m + d;
      if (acc_m > 32767)  acc_m = 32767;
      if (acc_m < -32768) acc_m = -32768;
    end
    check("pos_at_latency", {16'h0, sw1[15:0]}, {16'h0, pos_m});
    check("error_flag", 32'(er1), 32'(err_m));
    repeat (extra) tick();
  endtask

  initial begin
    int unsigned c0;
    int unsigned c2;
    int          d;
    logic [1:0]  ab2;
    logic [1:0]  nab;

    reset_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; ab1 = 2'b11;
    a2 = 1'b0; b2 = 1'b0; ab2 = 2'b00;
    clear1 = 1'b0; clear2 = 1'b0;
    pos_m = '0; err_m = 1'b0; acc_m = 0;

    // 1: reset with A=B=1 held, then settle
    repeat (3) @(negedge clk);
    check("rst_word", sw1, 32'h0);
    check("rst_err", 32'(er1), 32'h0);
    check("rst_strobe", 32'(st1), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("settle_word", sw1, 32'h0);
      check("settle_strobe", 32'(st1), 32'h0);
      check("settle_err", 32'(er1), 32'h0);
    end

    // 2: 8 forward, 10 reverse, 2 forward across the wrap, then a random walk
    for (int i = 0; i < 8; i++) step1(fwd(ab1), 20 - LAT1);
    check("pos_fwd8", {16'h0, sw1[15:0]}, 32'h0008);
    for (int i = 0; i < 10; i++) step1(rev(ab1), 20 - LAT1);
    check("pos_rev10", {16'h0, sw1[15:0]}, 32'hFFFE);
    for (int i = 0; i < 2; i++) step1(fwd(ab1), 20 - LAT1);
    check("pos_wrap_up", {16'h0, sw1[15:0]}, 32'h0000);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) step1(fwd(ab1), $urandom_range(0, 15));
      else                           step1(rev(ab1), $urandom_range(0, 15));
    end

    // 3: 3-cycle glitch ignored, 4-cycle pulse accepted then reverted
    nab = ab1 ^ 2'b10;
    {a1, b1} = nab;
    repeat (3) tick();
    {a1, b1} = ab1;
    repeat (12) tick();
    check("glitch3_pos", {16'h0, sw1[15:0]}, {16'h0, pos_m});
    check("glitch3_err", 32'(er1), 32'h0);
    d = step_of(ab1, nab);
    {a1, b1} = nab;
    repeat (4) tick();
    {a1, b1} = ab1;
    repeat (3) tick();
    check("pulse4_pos", {16'h0, sw1[15:0]}, {16'h0, pos_m + 16'(d)});
    repeat (4) tick();
    check("pulse4_back", {16'h0, sw1[15:0]}, {16'h0, pos_m});
    check("pulse4_err", 32'(er1), 32'h0);

    // 4: illegal double transition, then clear
    step1(ab1 ^ 2'b11, 5);
    check("illegal_err", 32'(er1), 32'h1);
    clear1 = 1'b1;
    tick();
    clear1 = 1'b0;
    pos_m = '0; err_m = 1'b0;
    check("clear_word", sw1, 32'h0);
    check("clear_err", 32'(er1), 32'h0);
    step1(fwd(ab1), 5);

    // 5: velocity sampling over aligned periods
    clear1 = 1'b1;
    tick();
    clear1 = 1'b0;
    c0 = cyc; pos_m = '0; acc_m = 0;
    for (int i = 0; i < 5; i++) step1(fwd(ab1), 20 - LAT1);
    wait_until(c0 + P1 - 1);
    check("p1_no_strobe_early", 32'(st1), 32'h0);
    tick();
    check("p1_strobe", 32'(st1), 32'h1);
    check("p1_word", sw1, {16'(acc_m), pos_m});
    check("p1_vel_5", {16'h0, sw1[31:16]}, 32'h0005);
    acc_m = 0;
    tick();
    check("p1_strobe_one_cycle", 32'(st1), 32'h0);
    check("p1_vel_hold", {16'h0, sw1[31:16]}, 32'h0005);
    wait_until(c0 + 2 * P1);
    check("p2_strobe", 32'(st1), 32'h1);
    check("p2_vel_idle", {16'h0, sw1[31:16]}, 32'h0000);
    for (int i = 0; i < 3; i++) step1(rev(ab1), $urandom_range(0, 20));
    wait_until(c0 + 3 * P1);
    check("p3_strobe", 32'(st1), 32'h1);
    check("p3_vel_m3", {16'h0, sw1[31:16]}, 32'h0000FFFD);
    acc_m = 0;
    for (int i = 0; i < 2; i++) step1(fwd(ab1), 10);
    wait_until(c0 + 4 * P1 - 1);
    clear1 = 1'b1;
    tick();
    clear1 = 1'b0;
    pos_m = '0; acc_m = 0;
    check("clr_tc_word", sw1, 32'h0);
    check("clr_tc_strobe", 32'(st1), 32'h0);
    check("clr_tc_err", 32'(er1), 32'h0);
    wait_until(c0 + 5 * P1);
    check("p5_strobe_restart", 32'(st1), 32'h1);
    check("p5_vel", {16'h0, sw1[31:16]}, 32'h0000);

    // Reset mid-operation, with a sticky error pending
    step1(ab1 ^ 2'b11, 3);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_word", sw1, 32'h0);
    check("async_rst_err", 32'(er1), 32'h0);
    check("async_rst_strobe", 32'(st1), 32'h0);
    pos_m = '0; err_m = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rerelease_word", sw1, 32'h0);
      check("rerelease_strobe", 32'(st1), 32'h0);
    end

    // 6: one forward step per cycle with FILTER_LEN=1 saturates velocity
    repeat (4) tick();
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    c2 = cyc;
    for (int i = 0; i < NSAT; i++) begin
      ab2 = fwd(ab2);
      {a2, b2} = ab2;
      tick();
    end
    wait_until(c2 + P2 - 1);
    check("sat_no_strobe_early", 32'(st2), 32'h0);
    check("sat_pos_wrapped", {16'h0, sw2[15:0]}, 32'(NSAT % 65536));
    tick();
    check("sat_strobe", 32'(st2), 32'h1);
    check("sat_word", sw2, {16'h7FFF, 16'(NSAT % 65536)});
    check("sat_err", 32'(er2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
